// File: rtl/tdm_mux_n_if.sv
// Bus bundle for tdm_mux_n: channel inputs, select controls and registered outputs.
// dout_par is present only when TDM_MUX_PARITY_EN is defined.
interface tdm_mux_n_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NCH   = 4,
  parameter int unsigned SEL_W = 2
);
  logic                   en;
  logic                   mode;
  logic [SEL_W-1:0]       sel_in;
  logic [NCH*WIDTH-1:0]   din;
  logic [WIDTH-1:0]       dout;
  logic                   dout_vld;
  logic [SEL_W-1:0]       cur_sel;
  logic                   wrap;
  logic                   sel_err;
`ifdef TDM_MUX_PARITY_EN
  logic                   dout_par;

  modport master (
    output en, mode, sel_in, din,
    input  dout, dout_vld, cur_sel, wrap, sel_err, dout_par
  );
  modport slave (
    input  en, mode, sel_in, din,
    output dout, dout_vld, cur_sel, wrap, sel_err, dout_par
  );
`else
  modport master (
    output en, mode, sel_in, din,
    input  dout, dout_vld, cur_sel, wrap, sel_err
  );
  modport slave (
    input  en, mode, sel_in, din,
    output dout, dout_vld, cur_sel, wrap, sel_err
  );
`endif
endinterface

// File: rtl/tdm_mux_n.sv
// NCH-input registered multiplexer with manual select or time-division auto scan.
// Optional even-parity output dout_par is built when TDM_MUX_PARITY_EN is defined.
module tdm_mux_n #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NCH   = 4,
  parameter int unsigned SEL_W = 2,
  parameter int unsigned DWELL = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  tdm_mux_n_if.slave  bus
);
  localparam int unsigned     CNT_W    = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NCH - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DWELL - 1);

  typedef enum logic [1:0] {IDLE, MANUAL, SCAN} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [SEL_W-1:0] sel_q;
  logic [SEL_W-1:0] sel_nxt;
  logic [WIDTH-1:0] dout_q;
  logic             wrap_q;
  logic             err_q;
  logic [WIDTH-1:0] ch [NCH];

  always_comb begin
    for (int unsigned k = 0; k < NCH; k++) begin
      ch[k] = bus.din[k*WIDTH +: WIDTH];
    end
  end

  // dout is loaded from the channel selected after this edge, keeping cur_sel aligned with dout
  always_comb begin
    sel_nxt = sel_q;
    if (bus.en) begin
      if (bus.mode) begin
        if (cnt == LAST_CNT) begin
          sel_nxt = (sel_q == LAST_SEL) ? '0 : sel_q + 1'b1;
        end
      end else if (bus.sel_in <= LAST_SEL) begin
        sel_nxt = bus.sel_in;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      sel_q  <= '0;
      dout_q <= '0;
      wrap_q <= 1'b0;
      err_q  <= 1'b0;
    end else if (bus.en) begin
      sel_q  <= sel_nxt;
      dout_q <= ch[sel_nxt];
      if (bus.mode) begin
        state  <= SCAN;
        err_q  <= 1'b0;
        cnt    <= (cnt == LAST_CNT) ? '0 : cnt + 1'b1;
        wrap_q <= (cnt == LAST_CNT) && (sel_q == LAST_SEL);
      end else begin
        state  <= MANUAL;
        cnt    <= '0;
        wrap_q <= 1'b0;
        err_q  <= (bus.sel_in > LAST_SEL);
      end
    end else begin
      state  <= IDLE;
      wrap_q <= 1'b0;
      err_q  <= 1'b0;
    end
  end

  assign bus.dout     = dout_q;
  assign bus.dout_vld = (state != IDLE);
  assign bus.cur_sel  = sel_q;
  assign bus.wrap     = wrap_q;
  assign bus.sel_err  = err_q;

`ifdef TDM_MUX_PARITY_EN
  logic par_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_q <= 1'b0;
    end else if (bus.en) begin
      par_q <= ^ch[sel_nxt];
    end
  end

  assign bus.dout_par = par_q;
`endif
endmodule

// File: doc/tdm_mux_n.md
Name: tdm_mux_n

Overview:
- Parametrised successor to the team's 2:1 multiplexer: an NCH-input, WIDTH-bit registered multiplexer.
- Two select modes:
  - manual: select comes from a port.
  - auto: time-division scan that dwells DWELL cycles on each channel, then advances.
- Used as the channel-selection stage ahead of shared downstream logic, such as a single serialiser or monitor fed by several sources.

Parameters:
- WIDTH, 8, bit width of each data channel.
- NCH, 4, number of input channels; legal range 2 to 2**SEL_W.
- SEL_W, 2, width of the select fields.
- DWELL, 4, cycles spent on each channel in auto mode; must be 1 or more.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset; assertion is asynchronous, release is synchronous to clk.
- en  in  1  block enable; when low, dout holds its value and no new samples are taken.
- mode  in  1  0 = manual select, 1 = auto scan.
- sel_in  in  SEL_W  manual channel select.
- din  in  NCH*WIDTH  flattened inputs; channel k occupies bits [k*WIDTH +: WIDTH].
- dout  out  WIDTH  registered selected data.
- dout_vld  out  1  high in any cycle where dout was updated by the previous edge.
- cur_sel  out  SEL_W  channel currently driving dout.
- wrap  out  1  one-cycle pulse when auto scan advances from NCH-1 back to 0.
- sel_err  out  1  one-cycle pulse when a manual sel_in is greater than NCH-1.

Behaviour:
- Reset values: dout=0, dout_vld=0, cur_sel=0, wrap=0, sel_err=0, dwell counter=0, state=IDLE. Reset asserted mid-scan aborts immediately, with no partial output.
- State machine:
  - IDLE (en=0): all registers hold; dout_vld=0, wrap=0, sel_err=0.
  - MANUAL (en=1, mode=0).
  - SCAN (en=1, mode=1).
  - State is re-evaluated at every edge from en and mode.
- Latency: one cycle. At edge t, dout <= din channel cur_sel_next; dout_vld=1 after any edge taken in MANUAL or SCAN.
- MANUAL:
  - If sel_in <= NCH-1: cur_sel_next = sel_in.
  - Otherwise: cur_sel_next = cur_sel (hold), sel_err pulses, and dout still samples the held channel with dout_vld=1.
  - The dwell counter is held at 0.
- SCAN:
  - The dwell counter counts 0 to DWELL-1.
  - On the edge where the counter equals DWELL-1, the counter wraps to 0 and cur_sel advances by 1.
  - If cur_sel = NCH-1, it advances to 0 instead, and wrap pulses in the following cycle, coincident with cur_sel = 0.
  - dout samples channel cur_sel at each edge, so each channel appears on dout for exactly DWELL consecutive cycles.
  - DWELL=1: advances every cycle.
- Mode switches:
  - MANUAL to SCAN: the scan starts from the current cur_sel with the counter at 0, so the current channel gets a full DWELL.
  - SCAN to MANUAL: sel_in takes effect at the first edge; the counter is cleared.
  - en falling mid-dwell: counter and cur_sel freeze. en rising resumes the same count with no reset of the dwell.
- Non-power-of-2 NCH: cur_sel never takes a value greater than NCH-1 in any mode.
- sel_in and mode are sampled only at edges where en=1; no glitch-through to dout is allowed, because dout is purely registered.

Optional Feature:
- Macro: TDM_MUX_PARITY_EN.
- Defined:
  - Adds output dout_par (1 bit), the even parity of dout; it is registered on the same edge as dout, so it is always consistent with it.
  - Resets to 0.
  - In IDLE it holds with dout.
- Undefined: the port is absent and no parity logic is built.

Test Plan:
- Reset and manual select: WIDTH=8, NCH=4, din={8'h44,8'h33,8'h22,8'h11}, release rst_n, en=1, mode=0, sel_in=2 → one edge later dout=8'h33, dout_vld=1, cur_sel=2.
- Auto scan: DWELL=4, mode=1 from cur_sel=0 → dout shows 8'h11 x4, 8'h22 x4, 8'h33 x4, 8'h44 x4, then 8'h11. wrap=1 only in the first 8'h11 cycle after the wrap.
- Invalid select: NCH=3, SEL_W=2, mode=0, cur_sel=1, sel_in=3 → sel_err pulses for one cycle, cur_sel stays 1, dout=channel 1 data.
- Enable freeze: in SCAN with the counter at 2 on channel 1, drop en for 5 cycles → dout, cur_sel and counter are unchanged and dout_vld=0. After en returns, channel 1 is held 2 more cycles, then channel 2.
- Asynchronous reset mid-scan: assert rst_n=0 between edges while in SCAN on channel 3 → dout, cur_sel, dout_vld and wrap go to 0 immediately, before any clock edge.
- Parity (macro defined): manual select of 8'h07 → dout_par=1. Manual select of 8'h03 → dout_par=0, aligned with dout.
